// File: rtl/counter_bn_pkg.sv
// Package wrapping the shared mode encodings for the counter_bn family.
package counter_bn_pkg;

`include "counter_defs.vh"

    function automatic logic is_count_mode(input logic [1:0] mode);
        return mode != MODE_LOAD;
    endfunction

endpackage

// File: rtl/counter_bn_next.sv
// Combinational next-count and carry/borrow flag for the three counting modes.
module counter_bn_next
    import counter_bn_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q_next,
    output logic             boundary
);

    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   STEP_EXT = STEP[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {WIDTH{1'b0}};
    localparam logic             SAT      = (SATURATE != 0);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("counter_bn_next: WIDTH must be at least 2");
        end
        if ((STEP < 1) || (STEP > (2 ** WIDTH) - 1)) begin : g_bad_step
            $error("counter_bn_next: STEP must lie in 1 .. 2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH:0] sum_up;
    logic [WIDTH:0] diff_one;
    logic [WIDTH:0] diff_step;

    // The extra MSB of each result is the carry (up) or borrow (down).
    always_comb begin
        sum_up    = {1'b0, q} + ONE_EXT;
        diff_one  = {1'b0, q} - ONE_EXT;
        diff_step = {1'b0, q} - STEP_EXT;
        q_next    = q;
        boundary  = 1'b0;
        case (mode)
            MODE_UP: begin
                boundary = sum_up[WIDTH];
                q_next   = (SAT && sum_up[WIDTH]) ? MAX_VAL : sum_up[WIDTH-1:0];
            end
            MODE_DN: begin
                boundary = diff_one[WIDTH];
                q_next   = (SAT && diff_one[WIDTH]) ? MIN_VAL : diff_one[WIDTH-1:0];
            end
            MODE_DNSTEP: begin
                boundary = diff_step[WIDTH];
                q_next   = (SAT && diff_step[WIDTH]) ? MIN_VAL : diff_step[WIDTH-1:0];
            end
            MODE_LOAD: begin
                // Loading is resolved by the register stage.
                q_next   = q;
                boundary = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/counter_defs.vh
// Mode encodings shared by the counter_bn family.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH

localparam logic [1:0] MODE_UP     = 2'b00;
localparam logic [1:0] MODE_DN     = 2'b01;
localparam logic [1:0] MODE_DNSTEP = 2'b10;
localparam logic [1:0] MODE_LOAD   = 2'b11;

`endif

// File: rtl/counter_bn.sv
// Multi-mode cascadable counter: registers plus reset/enable/mode priority.
module counter_bn
    import counter_bn_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             bn_clk,
    input  logic             bn_reset,
    input  logic             bn_enable,
    input  logic             bn_ci,
    input  logic [1:0]       bn_mode,
    input  logic [WIDTH-1:0] bn_D,
    output logic [WIDTH-1:0] bn_Q,
    output logic             bn_load,
    output logic             bn_rco
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             load_q;
    logic             load_d;
    logic             rco_q;
    logic             rco_d;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_boundary;

    counter_bn_next #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q_q),
        .mode     (bn_mode),
        .q_next   (cnt_next),
        .boundary (cnt_boundary)
    );

    always_comb begin
        q_d    = q_q;
        load_d = 1'b0;
        rco_d  = 1'b0;
        if (!bn_enable) begin
            q_d = '0;
        end else if (!is_count_mode(bn_mode)) begin
            q_d    = bn_D;
            load_d = 1'b1;
        end else if (bn_ci) begin
            q_d   = cnt_next;
            rco_d = cnt_boundary;
        end
    end

    always_ff @(posedge bn_clk) begin
        if (bn_reset) begin
            q_q    <= '0;
            load_q <= 1'b0;
            rco_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            load_q <= load_d;
            rco_q  <= rco_d;
        end
    end

    assign bn_Q    = q_q;
    assign bn_load = load_q;
    assign bn_rco  = rco_q;

endmodule
